// File: rtl/axi_mbox_pkg.sv
// AXI request/response bundles for the NoC mailbox slave port.
// Bus is 64 bits wide; the mailbox only uses the low 32-bit lane.
package axi_mbox_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef struct packed {
        logic [ID_W-1:0]   awid;
        logic [31:0]       awaddr;
        logic [7:0]        awlen;
        logic              awvalid;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              wlast;
        logic              wvalid;
        logic              bready;
        logic [ID_W-1:0]   arid;
        logic [31:0]       araddr;
        logic [7:0]        arlen;
        logic              arvalid;
        logic              rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic              awready;
        logic              wready;
        logic [ID_W-1:0]   bid;
        logic [1:0]        bresp;
        logic              bvalid;
        logic              arready;
        logic [ID_W-1:0]   rid;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rresp;
        logic              rlast;
        logic              rvalid;
    } s_axi_miso_t;

endpackage

// File: rtl/axi_mbox_slave.sv
// AXI slave mailbox: core stores feed a TX FIFO towards the NoC stream,
// NoC words land in an RX FIFO that the core pops by load.
module axi_mbox_slave
    import axi_mbox_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 14
) (
    input  logic        clk,
    input  logic        arst,
    input  s_axi_mosi_t axi_mosi,
    output s_axi_miso_t axi_miso,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic        rx_ready,
    output logic        irq
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] OFF_TX      = 2'd0;
    localparam logic [1:0] OFF_RX      = 2'd1;
    localparam logic [1:0] OFF_STATUS  = 2'd2;
    localparam logic [1:0] OFF_IRQ     = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t        w_state;
    logic [ID_W-1:0] w_id;
    logic [1:0]      w_off;
    logic [7:0]      w_len;
    logic [1:0]      w_resp;

    r_state_t        r_state;
    logic [ID_W-1:0] r_id;
    logic [1:0]      r_off;
    logic [7:0]      r_len;
    logic [7:0]      r_beat;
    logic [31:0]     r_data;
    logic [1:0]      r_resp;
    logic            r_pop;

    logic [1:0]      irq_en;

    logic [31:0]     tx_mem [DEPTH];
    logic [PW-1:0]   tx_wr, tx_rd;
    logic [CW-1:0]   tx_count;
    logic [31:0]     rx_mem [DEPTH];
    logic [PW-1:0]   rx_wr, rx_rd;
    logic [CW-1:0]   rx_count;

    logic [ADDR_W-1:0] aw_addr, ar_addr;
    logic unused_bits;

    assign aw_addr = axi_mosi.awaddr[ADDR_W-1:0];
    assign ar_addr = axi_mosi.araddr[ADDR_W-1:0];
    assign unused_bits = ^{axi_mosi.awaddr[31:ADDR_W], axi_mosi.araddr[31:ADDR_W],
                           aw_addr[ADDR_W-1:4], aw_addr[1:0],
                           ar_addr[ADDR_W-1:4], ar_addr[1:0],
                           axi_mosi.wdata[DATA_W-1:32], axi_mosi.wstrb[STRB_W-1:4]};

    logic tx_full, rx_full, rx_empty;
    logic w_beat, w_full_strb, w_apply, w_beat_err;
    logic tx_push, tx_pop, rx_push, rx_pop, r_hs;

    assign tx_full  = (tx_count == CW'(DEPTH));
    assign rx_full  = (rx_count == CW'(DEPTH));
    assign rx_empty = (rx_count == '0);

    assign w_beat      = (w_state == W_DATA) && axi_mosi.wvalid;
    assign w_full_strb = (axi_mosi.wstrb[3:0] == 4'hF);
    assign w_apply     = w_beat && (w_len == '0) && w_full_strb;
    assign w_beat_err  = w_beat && ((w_len != '0) ||
                         ((w_off == OFF_TX) && (!w_full_strb || tx_full)));

    // tx_full is the pre-pop view, so a push racing a stream pop is still refused
    assign tx_push  = w_apply && (w_off == OFF_TX) && !tx_full;
    assign tx_valid = (tx_count != '0);
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_data  = tx_mem[tx_rd];

    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && !rx_full;
    assign r_hs     = (r_state == R_DATA) && axi_mosi.rready;
    assign rx_pop   = r_hs && r_pop;

    assign irq = (irq_en[0] && (rx_count != '0)) || (irq_en[1] && (tx_count == '0));

    // Data for the next read beat. After a pop the head moves on, so look one
    // entry ahead, or forward a word being pushed into an otherwise drained FIFO.
    logic        head_ok;
    logic [31:0] head_data;
    logic [1:0]  fetch_off;
    logic [31:0] fetch_data;
    logic [1:0]  fetch_resp;
    logic        fetch_pop;

    always_comb begin
        head_ok   = 1'b0;
        head_data = '0;
        if ((r_state == R_DATA) && r_pop) begin
            if (rx_count > CW'(1)) begin
                head_ok   = 1'b1;
                head_data = rx_mem[rx_rd + PW'(1)];
            end else if (rx_push) begin
                head_ok   = 1'b1;
                head_data = rx_data;
            end
        end else begin
            head_ok   = !rx_empty;
            head_data = rx_mem[rx_rd];
        end

        fetch_off  = (r_state == R_IDLE) ? ar_addr[3:2] : r_off;
        fetch_data = '0;
        fetch_resp = RESP_OKAY;
        fetch_pop  = 1'b0;
        case (fetch_off)
            OFF_RX: begin
                if (head_ok) begin
                    fetch_data = head_data;
                    fetch_pop  = 1'b1;
                end else begin
                    fetch_resp = RESP_SLVERR;
                end
            end
            OFF_STATUS: fetch_data = {14'b0, rx_empty, tx_full, 8'(rx_count), 8'(tx_count)};
            OFF_IRQ:    fetch_data = {30'b0, irq_en};
            default:    fetch_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_off   <= '0;
            w_len   <= '0;
            w_resp  <= RESP_OKAY;
            irq_en  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (axi_mosi.awvalid) begin
                        w_id    <= axi_mosi.awid;
                        w_off   <= aw_addr[3:2];
                        w_len   <= axi_mosi.awlen;
                        w_resp  <= RESP_OKAY;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi_mosi.wvalid) begin
                        if (w_beat_err) w_resp <= RESP_SLVERR;
                        if (w_apply && (w_off == OFF_IRQ)) irq_en <= axi_mosi.wdata[1:0];
                        if (axi_mosi.wlast) w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axi_mosi.bready) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_off   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_data  <= '0;
            r_resp  <= RESP_OKAY;
            r_pop   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (axi_mosi.arvalid) begin
                        r_id    <= axi_mosi.arid;
                        r_off   <= ar_addr[3:2];
                        r_len   <= axi_mosi.arlen;
                        r_beat  <= '0;
                        r_data  <= fetch_data;
                        r_resp  <= fetch_resp;
                        r_pop   <= fetch_pop;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi_mosi.rready) begin
                        if (r_beat == r_len) begin
                            r_pop   <= 1'b0;
                            r_state <= R_IDLE;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            r_data <= fetch_data;
                            r_resp <= fetch_resp;
                            r_pop  <= fetch_pop;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + PW'(1);
            if (tx_pop)  tx_rd <= tx_rd + PW'(1);
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
            if (rx_push) rx_wr <= rx_wr + PW'(1);
            if (rx_pop)  rx_rd <= rx_rd + PW'(1);
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= axi_mosi.wdata[31:0];
        if (rx_push) rx_mem[rx_wr] <= rx_data;
    end

    always_comb begin
        axi_miso         = '0;
        axi_miso.awready = (w_state == W_IDLE);
        axi_miso.wready  = (w_state == W_DATA);
        axi_miso.bvalid  = (w_state == W_RESP);
        axi_miso.bid     = w_id;
        axi_miso.bresp   = w_resp;
        axi_miso.arready = (r_state == R_IDLE);
        axi_miso.rvalid  = (r_state == R_DATA);
        axi_miso.rid     = r_id;
        axi_miso.rdata   = {r_data, r_data};
        axi_miso.rresp   = r_resp;
        axi_miso.rlast   = (r_state == R_DATA) && (r_beat == r_len);
    end

endmodule

// File: tb/tb_axi_mbox_slave.sv
// Directed bench for axi_mbox_slave with queue-based expected responses,
// TX stream words and read beats.
module tb_axi_mbox_slave;
    import axi_mbox_pkg::*;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        arst;
    s_axi_mosi_t mosi;
    s_axi_miso_t miso;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_ready;
    logic        irq;

    always #5 clk = ~clk;

    axi_mbox_slave #(.DEPTH(8), .ADDR_W(14)) dut (
        .clk(clk), .arst(arst), .axi_mosi(mosi), .axi_miso(miso),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .irq(irq)
    );

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    bexp_t       exp_b[$];
    rexp_t       exp_r[$];
    logic [31:0] exp_tx[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_r(input logic [31:0] d, input logic [1:0] resp, input logic last,
                            input logic [3:0] id);
        rexp_t e;
        e.id   = id;
        e.data = {d, d};
        e.resp = resp;
        e.last = last;
        exp_r.push_back(e);
    endtask

    task automatic axi_write(input logic [1:0] off, input logic [31:0] d, input logic [7:0] strb,
                             input logic [7:0] len, input logic [3:0] id, input logic [1:0] resp,
                             input bit pop_on_beat);
        bit    got;
        int    t;
        bexp_t e;
        e.id   = id;
        e.resp = resp;
        exp_b.push_back(e);
        if (resp == OKAY && off == 2'd0) exp_tx.push_back(d);
        mosi.awvalid = 1'b1;
        mosi.awid    = id;
        mosi.awaddr  = 32'hA000_0000 | {28'h0, off, 2'b00};
        mosi.awlen   = len;
        got = 1'b0;
        t   = 0;
        while (!got && t < 50) begin
            @(negedge clk);
            got = miso.awready;
            tick();
            t++;
        end
        check("aw_handshake", 96'(got), 96'(1));
        mosi.awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            mosi.wvalid = 1'b1;
            mosi.wdata  = {~d, d};
            mosi.wstrb  = strb;
            mosi.wlast  = (b == int'(len));
            if (pop_on_beat) tx_ready = 1'b1;
            got = 1'b0;
            t   = 0;
            while (!got && t < 50) begin
                @(negedge clk);
                got = miso.wready;
                if (got && pop_on_beat && b == 0)
                    check("tx_pop_same_cycle", 96'({tx_valid, tx_data}), 96'({1'b1, exp_tx.pop_front()}));
                tick();
                t++;
            end
            tx_ready = 1'b0;
            check("w_handshake", 96'(got), 96'(1));
        end
        mosi.wvalid = 1'b0;
        mosi.wlast  = 1'b0;
        mosi.bready = 1'b1;
        got = 1'b0;
        t   = 0;
        while (!got && t < 50) begin
            @(negedge clk);
            got = miso.bvalid;
            if (got) begin
                e = exp_b.pop_front();
                check("bresp", 96'({miso.bid, miso.bresp}), 96'({e.id, e.resp}));
            end
            tick();
            t++;
        end
        check("b_seen", 96'(got), 96'(1));
        mosi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [1:0] off, input logic [7:0] len, input logic [3:0] id,
                            input bit rx_on_beat, input logic [31:0] rxd);
        bit    got;
        bit    done;
        int    t;
        rexp_t e;
        mosi.arvalid = 1'b1;
        mosi.arid    = id;
        mosi.araddr  = 32'hA000_0000 | {28'h0, off, 2'b00};
        mosi.arlen   = len;
        got = 1'b0;
        t   = 0;
        while (!got && t < 50) begin
            @(negedge clk);
            got = miso.arready;
            tick();
            t++;
        end
        check("ar_handshake", 96'(got), 96'(1));
        mosi.arvalid = 1'b0;
        mosi.rready  = 1'b1;
        if (rx_on_beat) begin
            rx_valid = 1'b1;
            rx_data  = rxd;
        end
        done = 1'b0;
        t    = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            if (miso.rvalid) begin
                e = exp_r.pop_front();
                check("rbeat", 96'({miso.rid, miso.rdata, miso.rresp, miso.rlast}),
                      96'({e.id, e.data, e.resp, e.last}));
                done = miso.rlast;
            end
            tick();
            rx_valid = 1'b0;
            t++;
        end
        check("r_done", 96'(done), 96'(1));
        mosi.rready = 1'b0;
    endtask

    task automatic read_status(input logic [31:0] exp, input logic [3:0] id);
        expect_r(exp, OKAY, 1'b1, id);
        axi_read(2'd2, 8'd0, id, 1'b0, 32'h0);
    endtask

    task automatic rx_push(input logic [31:0] d);
        bit got;
        int t;
        rx_valid = 1'b1;
        rx_data  = d;
        got = 1'b0;
        t   = 0;
        while (!got && t < 50) begin
            @(negedge clk);
            got = rx_ready;
            tick();
            t++;
        end
        rx_valid = 1'b0;
        check("rx_handshake", 96'(got), 96'(1));
    endtask

    task automatic drain(input int n);
        int cnt;
        int t;
        tx_ready = 1'b1;
        cnt = 0;
        t   = 0;
        while (cnt < n && t < 100) begin
            @(negedge clk);
            if (tx_valid) begin
                check("tx_stream", 96'(tx_data), 96'(exp_tx.pop_front()));
                cnt++;
            end
            tick();
            t++;
        end
        tx_ready = 1'b0;
        check("drain_count", 96'(cnt), 96'(n));
        check("tx_empty_after_drain", 96'(tx_valid), 96'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mosi     = '0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        arst     = 1'b1;
        repeat (3) tick();
        arst = 1'b0;

        // Reset values
        check("reset_outputs",
              96'({miso.awready, miso.arready, miso.wready, miso.bvalid, miso.rvalid,
                   miso.rlast, tx_valid, rx_ready, irq}), 96'(9'b110000010));

        // Single TX store
        axi_write(2'd0, 32'hDEAD_BEEF, 8'hFF, 8'd0, 4'd1, OKAY, 1'b0);
        check("tx_head_after_write", 96'({tx_valid, tx_data}), 96'({1'b1, 32'hDEAD_BEEF}));
        read_status(32'h0002_0001, 4'd2);
        drain(1);

        // Fill TX FIFO past DEPTH
        for (int i = 0; i < 9; i++)
            axi_write(2'd0, 32'h1000_0000 + i, 8'hFF, 8'd0, i[3:0], (i < 8) ? OKAY : SLVERR, 1'b0);
        read_status(32'h0003_0008, 4'd3);
        drain(8);

        // Rejected writes, STATUS write, TX_DATA read
        axi_write(2'd0, 32'hBAD0_0001, 8'hF3, 8'd0, 4'd4, SLVERR, 1'b0);
        axi_write(2'd0, 32'hBAD0_0002, 8'hFF, 8'd1, 4'd5, SLVERR, 1'b0);
        check("no_push_on_error", 96'(tx_valid), 96'(0));
        axi_write(2'd2, 32'hFFFF_FFFF, 8'hFF, 8'd0, 4'd6, OKAY, 1'b0);
        expect_r(32'h0, OKAY, 1'b1, 4'd7);
        axi_read(2'd0, 8'd0, 4'd7, 1'b0, 32'h0);
        read_status(32'h0002_0000, 4'd8);

        // RX burst read running past the last entry
        rx_push(32'h11);
        rx_push(32'h22);
        rx_push(32'h33);
        expect_r(32'h11, OKAY, 1'b0, 4'd9);
        expect_r(32'h22, OKAY, 1'b0, 4'd9);
        expect_r(32'h33, OKAY, 1'b0, 4'd9);
        expect_r(32'h00, SLVERR, 1'b1, 4'd9);
        axi_read(2'd1, 8'd3, 4'd9, 1'b0, 32'h0);
        read_status(32'h0002_0000, 4'd10);

        // Interrupt
        axi_write(2'd3, 32'h1, 8'hFF, 8'd0, 4'd11, OKAY, 1'b0);
        check("irq_rx_empty", 96'(irq), 96'(0));
        rx_push(32'h55);
        check("irq_rx_pending", 96'(irq), 96'(1));
        expect_r(32'h55, OKAY, 1'b1, 4'd12);
        axi_read(2'd1, 8'd0, 4'd12, 1'b0, 32'h0);
        check("irq_after_pop", 96'(irq), 96'(0));
        expect_r(32'h1, OKAY, 1'b1, 4'd13);
        axi_read(2'd3, 8'd0, 4'd13, 1'b0, 32'h0);
        axi_write(2'd3, 32'h2, 8'hFF, 8'd0, 4'd14, OKAY, 1'b0);
        check("irq_tx_empty", 96'(irq), 96'(1));
        axi_write(2'd3, 32'h0, 8'hFF, 8'd0, 4'd15, OKAY, 1'b0);
        check("irq_disabled", 96'(irq), 96'(0));

        // Full TX: push and stream pop in the same cycle
        for (int i = 0; i < 8; i++)
            axi_write(2'd0, 32'h2000_0000 + i, 8'hFF, 8'd0, 4'd1, OKAY, 1'b0);
        axi_write(2'd0, 32'hF00D_F00D, 8'hFF, 8'd0, 4'd2, SLVERR, 1'b1);
        read_status(32'h0002_0007, 4'd3);
        drain(7);

        // Empty RX: stream push and AXI pop in the same cycle
        expect_r(32'h0, SLVERR, 1'b1, 4'd4);
        axi_read(2'd1, 8'd0, 4'd4, 1'b1, 32'h77);
        read_status(32'h0000_0100, 4'd5);
        expect_r(32'h77, OKAY, 1'b1, 4'd6);
        axi_read(2'd1, 8'd0, 4'd6, 1'b0, 32'h0);

        // Reset in the middle of a write
        for (int i = 0; i < 3; i++)
            axi_write(2'd0, 32'h3000_0000 + i, 8'hFF, 8'd0, 4'd7, OKAY, 1'b0);
        mosi.awvalid = 1'b1;
        mosi.awid    = 4'd8;
        mosi.awaddr  = 32'hA000_0000;
        mosi.awlen   = 8'd0;
        tick();
        mosi.awvalid = 1'b0;
        check("in_w_data", 96'(miso.wready), 96'(1));
        arst = 1'b1;
        tick();
        arst = 1'b0;
        check("abandoned_write",
              96'({miso.bvalid, tx_valid, miso.wready, miso.awready}), 96'(4'b0001));
        exp_tx.delete();
        read_status(32'h0002_0000, 4'd9);
        axi_write(2'd0, 32'hCAFE_0001, 8'hFF, 8'd0, 4'd10, OKAY, 1'b0);
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
